// File: rtl/axi_arb_pkg.sv
// Shared types and AXI constants for the round-robin AXI arbiter.
package axi_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_ADDR_DATA,
        WR_RESP
    } arb_state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int ID_W = 4;

    // AxSIZE encoding for a full-width beat of the given data bus
    function automatic logic [2:0] axsize(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational grant selection: round-robin from last_grant+1, or fixed
// lowest-index priority when ARB_FIXED_PRIO_EN is defined.
module rr_picker #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
`ifndef ARB_FIXED_PRIO_EN
    input  logic [IDX_W-1:0] last_grant,
`endif
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    // Scan from lowest to highest priority so the last hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
`ifdef ARB_FIXED_PRIO_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) grant_idx = IDX_W'(i);
        end
`else
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last_grant) + k) % N])
                grant_idx = IDX_W'((int'(last_grant) + k) % N);
        end
`endif
        if (|req) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/axi_rr_arbiter.sv
// N-master to 1-slave AXI4 arbiter, one transaction outstanding.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module axi_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                          clock,
    input  logic                          reset,

    input  logic [N_MASTERS-1:0]          m_arvalid,
    output logic [N_MASTERS-1:0]          m_arready,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_araddr,
    input  logic [N_MASTERS*8-1:0]        m_arlen,
    output logic [N_MASTERS-1:0]          m_rvalid,
    output logic [N_MASTERS-1:0]          m_rlast,
    input  logic [N_MASTERS-1:0]          m_rready,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [1:0]                    m_rresp,

    input  logic [N_MASTERS-1:0]          m_awvalid,
    output logic [N_MASTERS-1:0]          m_awready,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_awaddr,
    input  logic [N_MASTERS*8-1:0]        m_awlen,
    input  logic [N_MASTERS-1:0]          m_wvalid,
    input  logic [N_MASTERS-1:0]          m_wlast,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb,
    output logic [N_MASTERS-1:0]          m_wready,
    output logic [N_MASTERS-1:0]          m_bvalid,
    input  logic [N_MASTERS-1:0]          m_bready,
    output logic [1:0]                    m_bresp,

    output logic                          s_arvalid,
    input  logic                          s_arready,
    output logic [ADDR_W-1:0]             s_araddr,
    output logic [7:0]                    s_arlen,
    output logic [2:0]                    s_arsize,
    output logic [1:0]                    s_arburst,
    output logic [ID_W-1:0]               s_arid,
    input  logic                          s_rvalid,
    output logic                          s_rready,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic [1:0]                    s_rresp,
    input  logic                          s_rlast,

    output logic                          s_awvalid,
    input  logic                          s_awready,
    output logic [ADDR_W-1:0]             s_awaddr,
    output logic [7:0]                    s_awlen,
    output logic [2:0]                    s_awsize,
    output logic [1:0]                    s_awburst,
    output logic [ID_W-1:0]               s_awid,
    output logic                          s_wvalid,
    input  logic                          s_wready,
    output logic [DATA_W-1:0]             s_wdata,
    output logic [DATA_W/8-1:0]           s_wstrb,
    output logic                          s_wlast,
    input  logic                          s_bvalid,
    output logic                          s_bready,
    input  logic [1:0]                    s_bresp
);

    localparam int          IDX_W  = $clog2(N_MASTERS);
    localparam int          STRB_W = DATA_W / 8;
    localparam logic [2:0]  SIZE   = axsize(DATA_W);

    logic [N_MASTERS-1:0][ADDR_W-1:0] araddr_v, awaddr_v;
    logic [N_MASTERS-1:0][7:0]        arlen_v, awlen_v;
    logic [N_MASTERS-1:0][DATA_W-1:0] wdata_v;
    logic [N_MASTERS-1:0][STRB_W-1:0] wstrb_v;

    assign araddr_v = m_araddr;
    assign awaddr_v = m_awaddr;
    assign arlen_v  = m_arlen;
    assign awlen_v  = m_awlen;
    assign wdata_v  = m_wdata;
    assign wstrb_v  = m_wstrb;

    arb_state_t            state;
    logic [IDX_W-1:0]      gnt;
    logic                  ar_pend, aw_pend, w_pend;
    logic [N_MASTERS-1:0]  req, pick_oh;
    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_rd;
    logic                  ar_hs, r_hs, aw_hs, wl_hs, b_hs;

    assign req     = m_arvalid | m_awvalid;
    assign pick_rd = |(m_arvalid & pick_oh);

`ifndef ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0] last_grant;
`endif

    rr_picker #(.N(N_MASTERS)) u_picker (
        .req        (req),
`ifndef ARB_FIXED_PRIO_EN
        .last_grant (last_grant),
`endif
        .grant      (pick_oh),
        .grant_idx  (pick_idx)
    );

    assign ar_hs = s_arvalid & s_arready;
    assign r_hs  = s_rvalid & s_rready;
    assign aw_hs = s_awvalid & s_awready;
    assign wl_hs = s_wvalid & s_wready & s_wlast;
    assign b_hs  = s_bvalid & s_bready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= '0;
            ar_pend <= 1'b0;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last_grant <= IDX_W'(N_MASTERS - 1);
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        gnt <= pick_idx;
`ifndef ARB_FIXED_PRIO_EN
                        last_grant <= pick_idx;
`endif
                        // Reads win when the chosen master has both pending
                        if (pick_rd) begin
                            state   <= RD_ADDR;
                            ar_pend <= 1'b1;
                        end else begin
                            state   <= WR_ADDR_DATA;
                            aw_pend <= 1'b1;
                            w_pend  <= 1'b1;
                        end
                    end
                end
                RD_ADDR: begin
                    if (ar_hs) begin
                        ar_pend <= 1'b0;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_hs && s_rlast) state <= IDLE;
                end
                WR_ADDR_DATA: begin
                    if (aw_hs) aw_pend <= 1'b0;
                    if (wl_hs) w_pend  <= 1'b0;
                    // AW and last W may complete in either order or together
                    if ((!aw_pend || aw_hs) && (!w_pend || wl_hs)) state <= WR_RESP;
                end
                WR_RESP: begin
                    if (b_hs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s_arvalid = ar_pend;
    assign s_araddr  = araddr_v[gnt];
    assign s_arlen   = arlen_v[gnt];
    assign s_arsize  = SIZE;
    assign s_arburst = BURST_INCR;
    assign s_arid    = ID_W'(gnt);
    assign s_rready  = (state == RD_DATA) & m_rready[gnt];

    assign s_awvalid = aw_pend;
    assign s_awaddr  = awaddr_v[gnt];
    assign s_awlen   = awlen_v[gnt];
    assign s_awsize  = SIZE;
    assign s_awburst = BURST_INCR;
    assign s_awid    = ID_W'(gnt);
    assign s_wvalid  = w_pend & m_wvalid[gnt];
    assign s_wdata   = wdata_v[gnt];
    assign s_wstrb   = wstrb_v[gnt];
    assign s_wlast   = m_wlast[gnt];
    assign s_bready  = (state == WR_RESP) & m_bready[gnt];

    assign m_rdata = s_rdata;
    assign m_rresp = s_rresp;
    assign m_bresp = s_bresp;

    // Only the owner of the current transaction ever sees a handshake
    always_comb begin
        m_arready = '0;
        m_rvalid  = '0;
        m_rlast   = '0;
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        m_arready[gnt] = ar_pend & s_arready;
        m_rvalid[gnt]  = (state == RD_DATA) & s_rvalid;
        m_rlast[gnt]   = (state == RD_DATA) & s_rlast;
        m_awready[gnt] = aw_pend & s_awready;
        m_wready[gnt]  = w_pend & s_wready;
        m_bvalid[gnt]  = (state == WR_RESP) & s_bvalid;
    end

endmodule
